seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, registered result out.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             busy;

    // Requester side
    modport master (
        output in_valid, in_A, in_B, ALUControl,
        input  in_ready, out_valid, ALUResult, zero, busy
    );

    // ALU side
    modport slave (
        input  in_valid, in_A, in_B, ALUControl,
        output in_ready, out_valid, ALUResult, zero, busy
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU. Logic/add/sub/slt complete in one cycle; MUL
// (shift-add) and, when SEQ_ALU_DIV_EN is defined, DIVU/REMU (restoring
// divide) take WIDTH iteration cycles. Without SEQ_ALU_DIV_EN the divide
// opcodes decode as ADD.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef SEQ_ALU_DIV_EN
        ,
        S_DIV  = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;

    logic             accept_c;
    logic             last_iter_c;
    logic             slt_c;
    logic [WIDTH-1:0] single_res_c;
    logic [WIDTH-1:0] mul_next_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.zero      = zero_q;

    assign accept_c    = bus.in_valid & in_ready_q;
    assign last_iter_c = (count == CNT_W'(WIDTH - 1));
    assign slt_c       = ($signed(bus.in_A) < $signed(bus.in_B));

    // Single-cycle result; unlisted opcodes fall through to ADD
    always_comb begin
        single_res_c = bus.in_A + bus.in_B;
        case (bus.ALUControl)
            OP_AND:  single_res_c = bus.in_A & bus.in_B;
            OP_OR:   single_res_c = bus.in_A | bus.in_B;
            OP_ADD:  single_res_c = bus.in_A + bus.in_B;
            OP_SUB:  single_res_c = bus.in_A - bus.in_B;
            OP_SLT:  single_res_c = {{(WIDTH - 1){1'b0}}, slt_c};
            OP_NOR:  single_res_c = ~(bus.in_A | bus.in_B);
            default: single_res_c = bus.in_A + bus.in_B;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set
    assign mul_next_c = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_dsor;
    logic             div_is_rem;
    logic             div_op_c;
    logic [WIDTH:0]   div_trial_c;
    logic             div_take_c;
    logic [WIDTH-1:0] div_rem_next_c;
    logic [WIDTH-1:0] div_quo_next_c;

    assign div_op_c    = (bus.ALUControl == OP_DIVU) || (bus.ALUControl == OP_REMU);
    assign div_trial_c = {div_rem, div_quo[WIDTH-1]} - {1'b0, div_dsor};
    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder
    assign div_take_c  = ~div_trial_c[WIDTH] | (div_dsor == '0);

    // One restoring-divide step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        div_rem_next_c = {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
        div_quo_next_c = {div_quo[WIDTH-2:0], 1'b0};
        if (div_take_c) begin
            div_rem_next_c = div_trial_c[WIDTH-1:0];
            div_quo_next_c = {div_quo[WIDTH-2:0], 1'b1};
        end
    end
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            mul_acc     <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_rem     <= '0;
            div_quo     <= '0;
            div_dsor    <= '0;
            div_is_rem  <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        count <= '0;
                        if (bus.ALUControl == OP_MUL) begin
                            state      <= S_MUL;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            mul_acc    <= '0;
                            mul_mcand  <= bus.in_A;
                            mul_mplier <= bus.in_B;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (div_op_c) begin
                            state      <= S_DIV;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            div_rem    <= '0;
                            div_quo    <= bus.in_A;
                            div_dsor   <= bus.in_B;
                            div_is_rem <= (bus.ALUControl == OP_REMU);
                        end
`endif
                        else begin
                            out_valid_q <= 1'b1;
                            result_q    <= single_res_c;
                            zero_q      <= (single_res_c == '0);
                        end
                    end
                end
                S_MUL: begin
                    if (last_iter_c) begin
                        state       <= S_IDLE;
                        count       <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_next_c;
                        zero_q      <= (mul_next_c == '0);
                    end else begin
                        count      <= count + CNT_W'(1);
                        mul_acc    <= mul_next_c;
                        mul_mcand  <= {mul_mcand[WIDTH-2:0], 1'b0};
                        mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    if (last_iter_c) begin
                        state       <= S_IDLE;
                        count       <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        if (div_is_rem) begin
                            result_q <= div_rem_next_c;
                            zero_q   <= (div_rem_next_c == '0);
                        end else begin
                            result_q <= div_quo_next_c;
                            zero_q   <= (div_quo_next_c == '0);
                        end
                    end else begin
                        count   <= count + CNT_W'(1);
                        div_rem <= div_rem_next_c;
                        div_quo <= div_quo_next_c;
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    count      <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result computed from the opcode table with plain arithmetic
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
            4'b1100: r = ~(a | b);
            4'b1000: r = a * b;
`ifdef SEQ_ALU_DIV_EN
            4'b1001: r = (b == '0) ? '1 : a / b;
            4'b1010: r = (b == '0) ? a : a % b;
`endif
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        int lat;
        lat = 1;
        if (op == 4'b1000) lat = W + 1;
`ifdef SEQ_ALU_DIV_EN
        if (op == 4'b1001 || op == 4'b1010) lat = W + 1;
`endif
        return lat;
    endfunction

    // Issue one op, measure cycles to out_valid, check result and busy behaviour
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit junk);
        logic [W-1:0] exp_r;
        int exp_lat;
        int lat;
        int bad;
        int wait_n;
        exp_r   = ref_result(op, a, b);
        exp_lat = ref_latency(op);
        wait_n  = 0;
        while (bus.in_ready !== 1'b1 && wait_n < 4 * W) begin
            step();
            wait_n++;
        end
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.in_A       = a;
        bus.in_B       = b;
        step();
        lat = 1;
        bad = 0;
        while (bus.out_valid !== 1'b1 && lat < 4 * W) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            if (junk) begin
                bus.in_valid   = 1'b1;
                bus.in_A       = $urandom;
                bus.in_B       = $urandom;
                bus.ALUControl = 4'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(bus.ALUResult), 64'(exp_r));
        check({name, " zero"}, 64'(bus.zero), 64'(exp_r == '0));
        if (exp_lat > 1) begin
            check({name, " busy phase"}, 64'(bad), 64'(0));
            check({name, " ready at done"}, 64'(bus.in_ready), 64'(1));
            check({name, " busy at done"}, 64'(bus.busy), 64'(0));
        end
    endtask

    initial begin
        logic [3:0] ops[10];
        logic [3:0] op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int pulses;

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1100, 4'b1000, 4'b0101, 4'b1001, 4'b1010};

        tbl[0]  = '{4'b0010, 32'd5,         32'd7,         32'd12,        1'b0};
        tbl[1]  = '{4'b0110, 32'd9,         32'd9,         32'd0,         1'b1};
        tbl[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
        tbl[3]  = '{4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1};
        tbl[4]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        tbl[5]  = '{4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0};
        tbl[6]  = '{4'b1100, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00, 1'b0};
        tbl[7]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        tbl[8]  = '{4'b0110, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        tbl[9]  = '{4'b0011, 32'd10,        32'd20,        32'd30,        1'b0};
        tbl[10] = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};

        // Reset state
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_A       = '0;
        bus.in_B       = '0;
        bus.ALUControl = 4'b0000;
        #12;
        check("reset in_ready", 64'(bus.in_ready), 64'(1));
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset ALUResult", 64'(bus.ALUResult), 64'(0));
        check("reset zero", 64'(bus.zero), 64'(0));

        // First edge after reset release accepts a request
        step();
        reset          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b0010;
        bus.in_A       = 32'd100;
        bus.in_B       = 32'd23;
        step();
        bus.in_valid = 1'b0;
        check("post-reset accept valid", 64'(bus.out_valid), 64'(1));
        check("post-reset accept result", 64'(bus.ALUResult), 64'(123));
        step();

        // Back-to-back single-cycle table
        for (int i = 0; i < 11; i++) begin
            bus.in_valid   = 1'b1;
            bus.ALUControl = tbl[i].op;
            bus.in_A       = tbl[i].a;
            bus.in_B       = tbl[i].b;
            step();
            check($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(1));
            check($sformatf("vec%0d result", i), 64'(bus.ALUResult), 64'(tbl[i].res));
            check($sformatf("vec%0d zero", i), 64'(bus.zero), 64'(tbl[i].z));
            check($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(1));
        end
        bus.in_valid = 1'b0;
        step();
        check("table pulse ends", 64'(bus.out_valid), 64'(0));
        check("table result held", 64'(bus.ALUResult), 64'(1));

        // Multi-cycle multiply, with requests offered while busy
        run_op("mul 0x10000^2", 4'b1000, 32'h0001_0000, 32'h0001_0000, 1'b1);
        run_op("mul 3x5", 4'b1000, 32'd3, 32'd5, 1'b1);
        step();
        check("mul pulse ends", 64'(bus.out_valid), 64'(0));
        check("mul result held", 64'(bus.ALUResult), 64'(15));
        run_op("mul wrap", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

`ifdef SEQ_ALU_DIV_EN
        run_op("divu 100/7", 4'b1001, 32'd100, 32'd7, 1'b1);
        run_op("remu 100/7", 4'b1010, 32'd100, 32'd7, 1'b0);
        run_op("divu 5/0", 4'b1001, 32'd5, 32'd0, 1'b1);
        run_op("remu 5/0", 4'b1010, 32'd5, 32'd0, 1'b0);
        run_op("divu big", 4'b1001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
`else
        run_op("1001 as add", 4'b1001, 32'd3, 32'd4, 1'b0);
        run_op("1010 as add", 4'b1010, 32'd8, 32'd9, 1'b0);
`endif

        // Reset during a multiply at iteration 10 aborts it
        run_op("pre-abort add", 4'b0010, 32'd40, 32'd2, 1'b0);
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b1000;
        bus.in_A       = 32'd3;
        bus.in_B       = 32'd5;
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        check("abort busy before reset", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        #1;
        check("abort in_ready", 64'(bus.in_ready), 64'(1));
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort out_valid", 64'(bus.out_valid), 64'(0));
        check("abort ALUResult", 64'(bus.ALUResult), 64'(0));
        step();
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 2 * W; c++) begin
            step();
            if (bus.out_valid === 1'b1) pulses++;
        end
        check("abort no out_valid", 64'(pulses), 64'(0));

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? '0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op($sformatf("rand%0d op%b", n, op), op, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
